mux_3_1_rr_arbiter: RTL and testbench

Round-robin arbiter and output stage that shares one 3:1 selector datapath among three requesters. Each requester presents a request and a data word. The block picks one requester per transfer, drives the selector code, and registers the selected word into a valid/ready output stage. It sits between three producer blocks and a single downstream consumer. It supplies the select code that the 3:1 mux datapath uses.

---
 rtl/mux_3_1_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_3_1_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_3_1_rr_arbiter.sv
// Round-robin arbiter for three requesters driving a registered 3:1 select/data output stage.
// Latency: gnt is combinational; the granted word appears on y with y_valid=1 one cycle later.
// Backpressure: while y_valid=1 and y_ready=0 no grant is issued and y/s/y_valid hold.
// Optional feature: define MUX_ARB_LOCK_EN to add the lock port (burst lock on the last winner).
module mux_3_1_rr_arbiter #(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
`ifdef MUX_ARB_LOCK_EN
    input  logic [2:0]    lock,
`endif
    output logic [2:0]    gnt,
    output logic [1:0]    s,
    output logic [DW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready
);

    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    s_q, s_d;
    logic [DW-1:0] y_q, y_d;
    logic          y_valid_q, y_valid_d;

    logic          take;
    logic          win_vld;
    logic [1:0]    win_idx;
    logic [1:0]    ord0, ord1, ord2;
    logic [DW-1:0] win_dat;

    // The stage accepts a new word when empty or when the current one leaves this cycle.
    assign take = ~y_valid_q | y_ready;

    // Search order starts just after the last winner and wraps; lock can pin the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        case (ptr_q)
            2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        if (req[ord0]) begin
            win_vld = 1'b1;
            win_idx = ord0;
        end else if (req[ord1]) begin
            win_vld = 1'b1;
            win_idx = ord1;
        end else if (req[ord2]) begin
            win_vld = 1'b1;
            win_idx = ord2;
        end
`ifdef MUX_ARB_LOCK_EN
        if (lock[ptr_q] && req[ptr_q]) begin
            win_vld = 1'b1;
            win_idx = ptr_q;
        end
`endif
    end

    // The shared 3:1 data selector steered by the winning index.
    always_comb begin
        case (win_idx)
            2'd0:    win_dat = d0;
            2'd1:    win_dat = d1;
            default: win_dat = d2;
        endcase
    end

    // Grant is one-hot and only while the stage can take a word and reset is released.
    always_comb begin
        gnt = 3'b000;
        if (take && win_vld && rst_n) begin
            gnt = 3'b001 << win_idx;
        end
    end

    // Next state: capture on a grant, drain when the consumer takes with nothing pending.
    always_comb begin
        ptr_d     = ptr_q;
        s_d       = s_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (take) begin
            if (win_vld) begin
                ptr_d     = win_idx;
                s_d       = win_idx;
                y_d       = win_dat;
                y_valid_d = 1'b1;
            end else if (y_ready) begin
                y_valid_d = 1'b0;
            end
        end
    end

    // State registers; ptr resets to 2 so requester 0 is first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 2'd2;
            s_q       <= 2'd0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            s_q       <= s_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign s       = s_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_3_1_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mux_3_1_rr_arbiter;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    lock;
    logic [2:0]    gnt;
    logic [1:0]    s;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          y_ready;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference state: what the output stage holds right now (or after the coming edge once adv runs).
    int m_valid, m_y, m_s, m_ptr;

    always #5 clk = ~clk;

    mux_3_1_rr_arbiter #(.DW(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
`ifdef MUX_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_y     = 0;
        m_s     = 0;
        m_ptr   = 2;
    endtask

    // Winner by the arbitration rules: lock on the last winner, else first requester after it.
    function automatic int winner();
        int w;
        w = -1;
`ifdef MUX_ARB_LOCK_EN
        if (lock[m_ptr] && req[m_ptr]) return m_ptr;
`endif
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + 1 + k) % 3;
            if (w < 0 && req[i]) w = i;
        end
        return w;
    endfunction

    // Compare all outputs against the reference at the falling edge.
    task automatic cyc();
        int w;
        logic [2:0] eg;
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
            chk("rst_gnt", gnt, 0);
            chk("rst_y_valid", y_valid, 0);
            chk("rst_y", y, 0);
            chk("rst_s", s, 0);
        end else begin
            w  = winner();
            eg = 3'b000;
            if ((m_valid == 0 || y_ready) && w >= 0) eg[w] = 1'b1;
            chk("model_gnt", gnt, eg);
            chk("model_y_valid", y_valid, m_valid);
            chk("model_y", y, m_y);
            chk("model_s", s, m_s);
        end
    endtask

    // Advance the reference across the rising edge, then step just past it.
    task automatic adv();
        int w;
        if (rst_n) begin
            w = winner();
            if (m_valid == 0 || y_ready) begin
                if (w >= 0) begin
                    m_valid = 1;
                    m_s     = w;
                    m_ptr   = w;
                    m_y     = (w == 0) ? int'(d0) : (w == 1) ? int'(d1) : int'(d2);
                end else if (y_ready) begin
                    m_valid = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = 3'b000;
        d0      = '0;
        d1      = '0;
        d2      = '0;
        lock    = 3'b000;
        y_ready = 1'b0;
        model_reset();

        repeat (2) begin cyc(); adv(); end
        rst_n   = 1'b1;
        y_ready = 1'b1;

        // Idle after reset
        repeat (5) begin
            cyc();
            chk("idle_y_valid", y_valid, 0);
            chk("idle_s", s, 0);
            chk("idle_y", y, 0);
            chk("idle_gnt", gnt, 0);
            adv();
        end

        // Fairness: all requesting, expect 0,1,2,0,1,2
        d0 = 3'd0; d1 = 3'd1; d2 = 3'd2; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("fair_gnt", gnt, 1 << (k % 3));
            if (k > 0) begin
                chk("fair_s", s, (k - 1) % 3);
                chk("fair_y", y, (k - 1) % 3);
            end
            adv();
        end
        req = 3'b000;
        cyc();
        chk("fair_last_s", s, 2);
        chk("fair_last_y", y, 2);
        chk("fair_last_valid", y_valid, 1);
        adv();

        // Single requester 1
        req = 3'b010; d1 = 3'b101;
        cyc();
        chk("single_gnt", gnt, 3'b010);
        adv();
        req = 3'b000;
        cyc();
        chk("single_y", y, 3'b101);
        chk("single_s", s, 1);
        chk("single_valid", y_valid, 1);
        adv();

        // Backpressure: last winner 1, so requester 2 first
        d1 = 3'd1; req = 3'b111;
        cyc();
        chk("bp_first_gnt", gnt, 3'b100);
        adv();
        y_ready = 1'b0;
        repeat (4) begin
            cyc();
            chk("bp_gnt", gnt, 0);
            chk("bp_s", s, 2);
            chk("bp_y", y, 2);
            chk("bp_valid", y_valid, 1);
            adv();
        end
        y_ready = 1'b1;
        cyc();
        chk("bp_resume_gnt", gnt, 3'b001);
        adv();
        y_ready = 1'b0;
        cyc();
        chk("bp_resume_s", s, 0);
        chk("bp_resume_valid", y_valid, 1);
        adv();

        // Reset pulse between edges while full
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", y_valid, 0);
        chk("midrst_gnt", gnt, 0);
        model_reset();
        #1 rst_n = 1'b1;
        y_ready = 1'b1;
        cyc();
        chk("midrst_first_gnt", gnt, 3'b001);
        adv();
        cyc();
        chk("midrst_s", s, 0);
        chk("midrst_y", y, 0);
        chk("midrst_gnt2", gnt, 3'b010);
        adv();

`ifdef MUX_ARB_LOCK_EN
        // Lock on requester 2 once it wins
        cyc();
        chk("lock_pre_gnt", gnt, 3'b100);
        lock = 3'b100;
        adv();
        repeat (3) begin
            cyc();
            chk("lock_s", s, 2);
            chk("lock_gnt", gnt, 3'b100);
            adv();
        end
        lock = 3'b000;
        cyc();
        chk("unlock_gnt", gnt, 3'b001);
        adv();
        cyc();
        chk("unlock_s", s, 0);
        adv();
`endif

        req = 3'b000;
        cyc();
        adv();
        cyc();
        adv();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
